// File: rtl/microcode_sequencer.sv
// microcode_sequencer: run-mode micro-op sequencer for the 8-bit bus CPU.
// Steps T0..T5 per instruction, parks in IDLE while the programmer owns the
// datapath, and sticks in HALT after an HLT until `programming` is pulsed.
// Optional build macro: EARLY_RETIRE_EN -- return to T0 right after the last
// non-idle micro-op of each opcode instead of padding every instruction to T5.
module microcode_sequencer #(
    parameter logic [14:0] IDLE_WORD = 15'h0FE3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        programming,
    input  logic [3:0]  opcode,
    output logic [14:0] control_word,
    output logic [2:0]  stage,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_T0   = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_IDLE = 3'd6,
        S_HALT = 3'd7
    } stage_t;

    // control word bit positions (names with a leading n are active-low)
    localparam int C_P   = 14;
    localparam int E_P   = 13;
    localparam int L_P   = 12;
    localparam int NL_MA = 11;
    localparam int NL_MD = 10;
    localparam int NCE   = 9;
    localparam int NL_R  = 8;
    localparam int NL_I  = 7;
    localparam int NE_I  = 6;
    localparam int NL_A  = 5;
    localparam int E_A   = 4;
    localparam int S_U   = 3;
    localparam int E_U   = 2;
    localparam int NL_B  = 1;
    localparam int NL_O  = 0;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    stage_t state;
    logic   retire;

`ifdef EARLY_RETIRE_EN
    logic is_nop;
    assign is_nop = (opcode >= 4'h6) && (opcode <= 4'hD);

    // flag the stage that carries the opcode's final useful micro-op
    always_comb begin
        retire = 1'b0;
        case (state)
            S_T1:    retire = is_nop;
            S_T2:    retire = (opcode == OP_LDI) || (opcode == OP_JMP) || (opcode == OP_OUT);
            S_T3:    retire = (opcode == OP_LDA);
            S_T4:    retire = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_STA);
            default: retire = 1'b0;
        endcase
    end
`else
    assign retire = 1'b0;
`endif

    // stage register; reset beats programming, programming beats everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (programming) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: state <= S_T0;
                S_HALT: state <= S_HALT;
                S_T5:   state <= S_T0;
                S_T2: begin
                    if (opcode == OP_HLT) state <= S_HALT;
                    else if (retire)      state <= S_T0;
                    else                  state <= S_T3;
                end
                default: begin
                    if (retire) state <= S_T0;
                    else        state <= stage_t'(state + 3'd1);
                end
            endcase
        end
    end

    // micro-op decode; unlisted signals keep their idle level
    always_comb begin
        control_word = IDLE_WORD;
        case (state)
            S_T0: begin
                control_word[E_P]   = 1'b1;
                control_word[NL_MA] = 1'b0;
            end
            S_T1: begin
                control_word[NCE]  = 1'b0;
                control_word[NL_I] = 1'b0;
                control_word[C_P]  = 1'b1;
            end
            S_T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        control_word[NE_I]  = 1'b0;
                        control_word[NL_MA] = 1'b0;
                    end
                    OP_LDI: begin
                        control_word[NE_I] = 1'b0;
                        control_word[NL_A] = 1'b0;
                    end
                    OP_JMP: begin
                        control_word[NE_I] = 1'b0;
                        control_word[L_P]  = 1'b1;
                    end
                    OP_OUT: begin
                        control_word[E_A]  = 1'b1;
                        control_word[NL_O] = 1'b0;
                    end
                    default: control_word = IDLE_WORD;
                endcase
            end
            S_T3: begin
                case (opcode)
                    OP_LDA: begin
                        control_word[NCE]  = 1'b0;
                        control_word[NL_A] = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        control_word[NCE]  = 1'b0;
                        control_word[NL_B] = 1'b0;
                    end
                    OP_STA: begin
                        control_word[E_A]   = 1'b1;
                        control_word[NL_MD] = 1'b0;
                    end
                    default: control_word = IDLE_WORD;
                endcase
            end
            S_T4: begin
                case (opcode)
                    OP_ADD: begin
                        control_word[E_U]  = 1'b1;
                        control_word[NL_A] = 1'b0;
                    end
                    OP_SUB: begin
                        control_word[E_U]  = 1'b1;
                        control_word[S_U]  = 1'b1;
                        control_word[NL_A] = 1'b0;
                    end
                    OP_STA: control_word[NL_R] = 1'b0;
                    default: control_word = IDLE_WORD;
                endcase
            end
            default: control_word = IDLE_WORD;
        endcase
    end

    assign stage  = state;
    assign halted = (state == S_HALT);

endmodule
